// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encodings.
package pwm_capture_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;  // not measuring
    localparam logic [1:0] ST_SEEK = 2'd1;  // waiting for the first rising edge
    localparam logic [1:0] ST_HIGH = 2'd2;  // input high, counting high and period
    localparam logic [1:0] ST_LOW  = 2'd3;  // input low, counting period only

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronises the asynchronous PWM input and produces a level together with
// registered rise/fall pulses that are cycle-aligned with that level.
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   lvl_d;

    // Metastability chain; the top bit is the first safe-to-use sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pwm_in};
        end
    end

    // Registered edge detect so the FSM only ever sees flop outputs; the
    // delayed level is what the pulses are aligned with.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            lvl_d <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~lvl_d;
            fall  <= ~chain[SYNC_STAGES-1] & lvl_d;
        end
    end

    assign s = lvl_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and full period of pwm_in in clk cycles,
// publishing one result pair per complete period with a one-cycle strobe, and
// flagging an input that stops toggling.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             meas_valid,
    output logic             timeout,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s;
    logic             rise;
    logic             fall;
    logic [1:0]       state;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] pcnt;

    pwm_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    // Measurement FSM with counters, result registers and sticky timeout.
    // In LOW a rise wins over saturation (a period of exactly CNT_MAX is
    // still reportable); in HIGH saturation wins since a fall would wrap pcnt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            hcnt         <= '0;
            pcnt         <= '0;
            high_count   <= '0;
            period_count <= '0;
            meas_valid   <= 1'b0;
            timeout      <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                state   <= ST_IDLE;
                hcnt    <= '0;
                pcnt    <= '0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_SEEK;
                    end
                    ST_SEEK: begin
                        if (rise) begin
                            state <= ST_HIGH;
                            hcnt  <= CNT_ONE;
                            pcnt  <= CNT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (pcnt == CNT_MAX) begin
                            state       <= ST_SEEK;
                            timeout     <= 1'b1;
                            stuck_level <= s;
                        end else if (fall) begin
                            state <= ST_LOW;
                            pcnt  <= pcnt + CNT_ONE;
                        end else begin
                            hcnt <= hcnt + CNT_ONE;
                            pcnt <= pcnt + CNT_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            high_count   <= hcnt;
                            period_count <= pcnt;
                            meas_valid   <= 1'b1;
                            timeout      <= 1'b0;
                            state        <= ST_HIGH;
                            hcnt         <= CNT_ONE;
                            pcnt         <= CNT_ONE;
                        end else if (pcnt == CNT_MAX) begin
                            state       <= ST_SEEK;
                            timeout     <= 1'b1;
                            stuck_level <= s;
                        end else begin
                            pcnt <= pcnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a small PWM source drives the input and
// each step checks results against hand-computed values.
module tb_pwm_capture;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    localparam int LAT   = SYNC + 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             pwm_in;
    logic [CNT_W-1:0] high_count;
    logic [CNT_W-1:0] period_count;
    logic             meas_valid;
    logic             timeout;
    logic             stuck_level;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // PWM source state
    logic gen_on    = 1'b0;
    logic gen_level = 1'b0;
    int   hi_n = 1, lo_n = 1, req = 0, ack = 0;
    int   rise_cyc = 0;
    int   rise_n   = 0;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .pwm_in       (pwm_in),
        .high_count   (high_count),
        .period_count (period_count),
        .meas_valid   (meas_valid),
        .timeout      (timeout),
        .stuck_level  (stuck_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PWM source: new hi/lo settings take effect only at a period boundary.
    initial begin
        int   hi, lo, ph;
        logic nxt;
        hi = 1; lo = 1; ph = 0;
        pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (req != ack && ph == 0) begin
                hi  = hi_n;
                lo  = lo_n;
                ack = req;
            end
            if (!gen_on) begin
                ph  = 0;
                nxt = gen_level;
            end else begin
                nxt = (ph < hi);
                ph  = (ph + 1 >= hi + lo) ? 0 : ph + 1;
            end
            if (nxt && !pwm_in) begin
                rise_cyc = cyc;
                rise_n   = rise_n + 1;
            end
            pwm_in = nxt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns the cycle of the next strobe, or -1 if none within max_c cycles.
    task automatic wait_strobe(input int max_c, output int at);
        at = -1;
        for (int i = 0; i < max_c; i++) begin
            @(negedge clk);
            if (meas_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Request new source timing, wait until applied, then let any strobe
    // belonging to the old waveform drain.
    task automatic set_gen(input int h, input int l);
        hi_n = h;
        lo_n = l;
        req  = req + 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (ack == req) break;
        end
        chk("gen_applied", ack, req);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int at, at2, nstb, to_cyc, r0;
        logic prev;

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_high_count", high_count, 0);
        chk("rst_period_count", period_count, 0);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_stuck_level", stuck_level, 0);
        rst_n = 1'b1;

        // 3 high / 3 low
        enable = 1'b1;
        gen_on = 1'b1;
        set_gen(3, 3);
        wait_strobe(60, at);
        chk("t1_strobe_seen", at >= 0, 1);
        chk("t1_high", high_count, 3);
        chk("t1_period", period_count, 6);
        @(negedge clk);
        chk("t1_strobe_one_cycle", meas_valid, 0);
        wait_strobe(60, at2);
        chk("t1_high2", high_count, 3);
        chk("t1_period2", period_count, 6);
        chk("t1_interval", at2 - at, 6);

        // 1 high / 7 low, then 7 high / 1 low
        set_gen(1, 7);
        wait_strobe(60, at);
        chk("t2_strobe_seen", at >= 0, 1);
        chk("t2_high_d0", high_count, 1);
        chk("t2_period_d0", period_count, 8);
        set_gen(7, 1);
        wait_strobe(60, at);
        chk("t2_high_d6", high_count, 7);
        chk("t2_period_d6", period_count, 8);

        // input stuck high: saturation at pcnt = 255
        enable    = 1'b0;
        gen_on    = 1'b0;
        gen_level = 1'b0;
        repeat (6) @(negedge clk);
        enable = 1'b1;
        repeat (6) @(negedge clk);
        gen_level = 1'b1;
        nstb   = 0;
        to_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (meas_valid) nstb++;
            if (timeout) begin
                to_cyc = cyc;
                break;
            end
        end
        chk("t3_timeout_set", timeout, 1);
        chk("t3_timeout_cycle", to_cyc - rise_cyc, 255 + LAT);
        chk("t3_stuck_level", stuck_level, 1);
        chk("t3_no_strobe", nstb, 0);
        repeat (5) @(negedge clk);
        chk("t3_timeout_sticky", timeout, 1);
        gen_on = 1'b1;
        set_gen(4, 4);
        chk("t3_timeout_before_resume", timeout, 1);
        wait_strobe(60, at);
        chk("t3_resume_seen", at >= 0, 1);
        chk("t3_timeout_cleared", timeout, 0);
        chk("t3_high", high_count, 4);
        chk("t3_period", period_count, 8);

        // enable dropped while in HIGH (right after a publish)
        wait_strobe(60, at);
        enable = 1'b0;
        nstb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (meas_valid) nstb++;
        end
        chk("t4_no_strobe_disabled", nstb, 0);
        chk("t4_high_held", high_count, 4);
        chk("t4_period_held", period_count, 8);
        prev = pwm_in;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev && !pwm_in) break;
            prev = pwm_in;
        end
        @(negedge clk);
        enable = 1'b1;
        r0 = rise_n;
        wait_strobe(60, at);
        chk("t4_reenable_seen", at >= 0, 1);
        chk("t4_rises_before_strobe", rise_n - r0, 2);
        chk("t4_latency", at - rise_cyc, LAT);
        chk("t4_high", high_count, 4);

        // reset asserted while in LOW
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_high", high_count, 0);
        chk("t5_rst_period", period_count, 0);
        chk("t5_rst_valid", meas_valid, 0);
        chk("t5_rst_timeout", timeout, 0);
        chk("t5_rst_stuck", stuck_level, 0);
        set_gen(3, 2);
        rst_n = 1'b1;
        wait_strobe(60, at);
        chk("t5_strobe_seen", at >= 0, 1);
        chk("t5_high", high_count, 3);
        chk("t5_period", period_count, 5);
        chk("t5_latency", at - rise_cyc, LAT);

        // minimum period: 1 high / 1 low
        set_gen(1, 1);
        at = -1;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(20, at2);
            chk("t6_strobe_seen", at2 >= 0, 1);
            chk("t6_high", high_count, 1);
            chk("t6_period", period_count, 2);
            if (k > 0) chk("t6_interval", at2 - at, 2);
            at = at2;
            @(negedge clk);
            chk("t6_gap", meas_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
